// File: rtl/pc_gen.sv
// pc_gen -- fetch-stage program-counter generator.
//
// Holds the fetch PC and offers it to instruction memory over a valid/ready
// handshake. Redirects (trap, flush) take effect one cycle after they are
// sampled and bump a small epoch tag so the fetch stage can discard responses
// to requests issued before the redirect. A BOOT cycle follows reset, and a
// debug HALT state suppresses fetch requests while still tracking redirects.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   pause     in   back-end stall; holds the PC and drops if_valid
//   flush     in   redirect request to flush_pc
//   flush_pc  in   redirect target (XLEN)
//   trap      in   exception redirect to TRAP_VEC
//   halt      in   debug halt request (level)
//   if_ready  in   instruction memory accepts the current PC
//   pc        out  current fetch PC
//   seq_pc    out  pc + INST_BYTES, modulo 2^XLEN
//   if_valid  out  pc is a valid fetch request
//   pc_epoch  out  epoch tag of the current request
//   misalign  out  one-cycle pulse after a misaligned flush target
//   halted    out  block is in the HALT state

module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VEC   = 32'h0000_0100,
    parameter int              INST_BYTES = 4,
    parameter int              EPOCH_W    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pause,
    input  logic               flush,
    input  logic [XLEN-1:0]    flush_pc,
    input  logic               trap,
    input  logic               halt,
    input  logic               if_ready,
    output logic [XLEN-1:0]    pc,
    output logic [XLEN-1:0]    seq_pc,
    output logic               if_valid,
    output logic [EPOCH_W-1:0] pc_epoch,
    output logic               misalign,
    output logic               halted
);

    localparam logic [XLEN-1:0]    PC_INC     = XLEN'(INST_BYTES);
    // Mask form of the low-bit check also works when INST_BYTES is 1.
    localparam logic [XLEN-1:0]    ALIGN_MASK = XLEN'(INST_BYTES - 1);
    localparam logic [EPOCH_W-1:0] EPOCH_ONE  = EPOCH_W'(1);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state_r;
    logic [XLEN-1:0]     pc_r;
    logic [EPOCH_W-1:0]  epoch_r;
    logic                misalign_r;

    logic                redirect_s;
    logic                misaligned_s;
    logic                accept_s;
    logic [XLEN-1:0]     pc_nxt_s;

    assign seq_pc       = pc_r + PC_INC;
    assign if_valid     = (state_r == ST_RUN) && !pause;
    assign halted       = (state_r == ST_HALT);
    assign pc           = pc_r;
    assign pc_epoch     = epoch_r;
    assign misalign     = misalign_r;

    assign redirect_s   = trap | flush;
    assign misaligned_s = |(flush_pc & ALIGN_MASK);
    assign accept_s     = if_valid & if_ready;

    // Next-PC selection in fixed priority: trap, aligned flush, misaligned flush, accept, hold.
    always_comb begin
        pc_nxt_s = pc_r;
        if (trap) begin
            pc_nxt_s = TRAP_VEC;
        end else if (flush && !misaligned_s) begin
            pc_nxt_s = flush_pc;
        end else if (flush) begin
            pc_nxt_s = TRAP_VEC;
        end else if (accept_s) begin
            pc_nxt_s = seq_pc;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // PC, epoch, misalign pulse and BOOT/RUN/HALT state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_VEC;
            epoch_r    <= '0;
            misalign_r <= 1'b0;
            state_r    <= ST_BOOT;
        end else begin
            pc_r <= pc_nxt_s;
            // Simultaneous trap and flush still count as one redirect.
            if (redirect_s) begin
                epoch_r <= epoch_r + EPOCH_ONE;
            end else begin
                epoch_r <= epoch_r;
            end
            // A trap outranks the flush, so the flush target is not reported.
            misalign_r <= flush & ~trap & misaligned_s;
            case (state_r)
                ST_BOOT: state_r <= ST_RUN;
                ST_RUN: begin
                    if (halt && !redirect_s) begin
                        state_r <= ST_HALT;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    if (!halt) begin
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_HALT;
                    end
                end
                default: state_r <= ST_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen. Each vector gives the inputs driven during
// one cycle and the outputs the DUT must show during that same cycle (i.e.
// the state left by the previous rising edge). Expected records go through a
// scoreboard queue and are compared shortly after the inputs settle.

module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst, pause, flush, trap, halt, if_ready;
    logic [31:0] flush_pc;
    logic [31:0] pc, seq_pc;
    logic        if_valid, misalign, halted;
    logic [1:0]  pc_epoch;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic        rst, pause, flush;
        logic [31:0] fpc;
        logic        trap, halt, rdy;
        logic [31:0] epc;
        logic [1:0]  eep;
        logic        ev, emis, eh;
    } vec_t;

    typedef struct {
        logic [31:0] epc;
        logic [1:0]  eep;
        logic        ev, emis, eh;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[31];

    pc_gen dut (
        .clk      (clk),
        .rst      (rst),
        .pause    (pause),
        .flush    (flush),
        .flush_pc (flush_pc),
        .trap     (trap),
        .halt     (halt),
        .if_ready (if_ready),
        .pc       (pc),
        .seq_pc   (seq_pc),
        .if_valid (if_valid),
        .pc_epoch (pc_epoch),
        .misalign (misalign),
        .halted   (halted)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic p, input logic f,
                                input logic [31:0] fpc, input logic t,
                                input logic h, input logic rdy,
                                input logic [31:0] epc, input logic [1:0] eep,
                                input logic ev, input logic emis, input logic eh);
        vec_t x;
        x.rst = r; x.pause = p; x.flush = f; x.fpc = fpc; x.trap = t;
        x.halt = h; x.rdy = rdy; x.epc = epc; x.eep = eep; x.ev = ev;
        x.emis = emis; x.eh = eh;
        return x;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector on the falling edge, check the DUT, leave the rising edge to apply it.
    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst = t.rst; pause = t.pause; flush = t.flush; flush_pc = t.fpc;
        trap = t.trap; halt = t.halt; if_ready = t.rdy;
        e.epc = t.epc; e.eep = t.eep; e.ev = t.ev; e.emis = t.emis; e.eh = t.eh;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        n_vec++;
        chk("pc",       idx, pc,                got.epc);
        chk("seq_pc",   idx, seq_pc,            got.epc + 32'd4);
        chk("pc_epoch", idx, {30'd0, pc_epoch}, {30'd0, got.eep});
        chk("if_valid", idx, {31'd0, if_valid}, {31'd0, got.ev});
        chk("misalign", idx, {31'd0, misalign}, {31'd0, got.emis});
        chk("halted",   idx, {31'd0, halted},   {31'd0, got.eh});
    endtask

    initial begin
        bit seen;
        //              rst p  f  fpc           t  h  rdy  pc            ep    v  mis h
        tbl[0]  = mk(1'b1,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h0,   2'd0, 1'b0,1'b0,1'b0); // reset state
        tbl[1]  = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h0,   2'd0, 1'b0,1'b0,1'b0); // BOOT
        tbl[2]  = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h0,   2'd0, 1'b1,1'b0,1'b0);
        tbl[3]  = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h4,   2'd0, 1'b1,1'b0,1'b0);
        tbl[4]  = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b0, 32'h8,   2'd0, 1'b1,1'b0,1'b0); // backpressure
        tbl[5]  = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b0, 32'h8,   2'd0, 1'b1,1'b0,1'b0);
        tbl[6]  = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b0, 32'h8,   2'd0, 1'b1,1'b0,1'b0);
        tbl[7]  = mk(1'b0,1'b1,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h8,   2'd0, 1'b0,1'b0,1'b0); // pause
        tbl[8]  = mk(1'b0,1'b1,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h8,   2'd0, 1'b0,1'b0,1'b0);
        tbl[9]  = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h8,   2'd0, 1'b1,1'b0,1'b0);
        tbl[10] = mk(1'b0,1'b1,1'b1,32'h200,  1'b0,1'b0,1'b1, 32'hC,   2'd0, 1'b0,1'b0,1'b0); // flush over pause
        tbl[11] = mk(1'b0,1'b1,1'b1,32'h204,  1'b0,1'b0,1'b1, 32'h200, 2'd1, 1'b0,1'b0,1'b0);
        tbl[12] = mk(1'b0,1'b1,1'b1,32'h208,  1'b0,1'b0,1'b1, 32'h204, 2'd2, 1'b0,1'b0,1'b0);
        tbl[13] = mk(1'b0,1'b1,1'b1,32'h20C,  1'b0,1'b0,1'b1, 32'h208, 2'd3, 1'b0,1'b0,1'b0);
        tbl[14] = mk(1'b0,1'b1,1'b1,32'h210,  1'b0,1'b0,1'b1, 32'h20C, 2'd0, 1'b0,1'b0,1'b0); // epoch wrap
        tbl[15] = mk(1'b0,1'b1,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h210, 2'd1, 1'b0,1'b0,1'b0);
        tbl[16] = mk(1'b0,1'b0,1'b1,32'h202,  1'b0,1'b0,1'b1, 32'h210, 2'd1, 1'b1,1'b0,1'b0); // misaligned + accept
        tbl[17] = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h100, 2'd2, 1'b1,1'b1,1'b0);
        tbl[18] = mk(1'b0,1'b0,1'b1,32'h300,  1'b1,1'b0,1'b1, 32'h104, 2'd2, 1'b1,1'b0,1'b0); // trap + flush
        tbl[19] = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b0, 32'h100, 2'd3, 1'b1,1'b0,1'b0);
        tbl[20] = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b1,1'b1, 32'h100, 2'd3, 1'b1,1'b0,1'b0); // halt entry with accept
        tbl[21] = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b1,1'b1, 32'h104, 2'd3, 1'b0,1'b0,1'b1);
        tbl[22] = mk(1'b0,1'b0,1'b1,32'h400,  1'b0,1'b1,1'b1, 32'h104, 2'd3, 1'b0,1'b0,1'b1); // flush while halted
        tbl[23] = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b1,1'b1, 32'h400, 2'd0, 1'b0,1'b0,1'b1);
        tbl[24] = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h400, 2'd0, 1'b0,1'b0,1'b1); // release halt
        tbl[25] = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h400, 2'd0, 1'b1,1'b0,1'b0);
        tbl[26] = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h404, 2'd0, 1'b1,1'b0,1'b0);
        tbl[27] = mk(1'b0,1'b0,1'b0,32'h0,    1'b1,1'b0,1'b1, 32'h408, 2'd0, 1'b1,1'b0,1'b0); // trap + accept
        tbl[28] = mk(1'b1,1'b0,1'b1,32'h500,  1'b0,1'b0,1'b1, 32'h100, 2'd1, 1'b1,1'b0,1'b0); // reset beats flush
        tbl[29] = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h0,   2'd0, 1'b0,1'b0,1'b0);
        tbl[30] = mk(1'b0,1'b0,1'b0,32'h0,    1'b0,1'b0,1'b1, 32'h0,   2'd0, 1'b1,1'b0,1'b0);

        rst = 1'b1; pause = 1'b0; flush = 1'b0; flush_pc = 32'h0;
        trap = 1'b0; halt = 1'b0; if_ready = 1'b1;
        @(posedge clk);

        for (int i = 0; i < 31; i++) apply(tbl[i], i);

        // PC wrap at the top of the address space.
        apply(mk(1'b0,1'b0,1'b1,32'hFFFF_FFFC,1'b0,1'b0,1'b0, 32'h4,         2'd0,1'b1,1'b0,1'b0), 100);
        apply(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1, 32'hFFFF_FFFC, 2'd1,1'b1,1'b0,1'b0), 101);
        apply(mk(1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0, 32'h0,         2'd1,1'b1,1'b0,1'b0), 102);

        // Reset then bounded wait for the first fetch request at RESET_VEC.
        apply(mk(1'b1,1'b0,1'b0,32'h0,1'b0,1'b0,1'b1, 32'h0,2'd1,1'b1,1'b0,1'b0), 103);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 5 && !seen; c++) begin
            #1;
            if (if_valid) seen = 1'b1;
            else @(negedge clk);
        end
        n_vec++;
        if (!seen) begin
            n_miss++;
            $display("FAIL boot_wait: if_valid got 0 expected 1 within 5 cycles");
        end else begin
            chk("boot_pc", 104, pc, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
